ml_qspi_slave: RTL



---
 rtl/ml_qspi_slave.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ml_qspi_slave.sv
// QSPI receive front end: oversamples the host bus, decodes one command byte per
// frame and queues write-burst bytes. Optional STATUS readback under ML_QSPI_STATUS_EN.
module ml_qspi_slave #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       spi_clk,
    input  logic       spi_csb,
    input  logic [3:0] spi_io_di,
    output logic [3:0] spi_io_do,
    output logic [3:0] spi_io_oe,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_data,
    output logic       cmd_start,
    input  logic [4:0] status_in,
    output logic       err,
    output logic [2:0] o_dbg_state
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WRITE  = 3'd2,
        ST_STATUS = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    logic [1:0] r_clk_s, r_csb_s;
    logic [3:0] r_io_s1, r_io_s2, r_io_e;
    logic       r_clk_d, r_csb_d;
    logic       r_rise, r_fall, r_csb_rise, r_csb_fall;

    // csb synchroniser resets low so a frame already in progress at release
    // never produces a falling edge; only a fresh high-to-low does.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clk_s    <= 2'b00;
            r_csb_s    <= 2'b00;
            r_io_s1    <= 4'h0;
            r_io_s2    <= 4'h0;
            r_clk_d    <= 1'b0;
            r_csb_d    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_csb_rise <= 1'b0;
            r_csb_fall <= 1'b0;
            r_io_e     <= 4'h0;
        end else begin
            r_clk_s    <= {r_clk_s[0], spi_clk};
            r_csb_s    <= {r_csb_s[0], spi_csb};
            r_io_s1    <= spi_io_di;
            r_io_s2    <= r_io_s1;
            r_clk_d    <= r_clk_s[1];
            r_csb_d    <= r_csb_s[1];
            r_rise     <= r_clk_s[1] & ~r_clk_d;
            r_fall     <= ~r_clk_s[1] & r_clk_d;
            r_csb_rise <= r_csb_s[1] & ~r_csb_d;
            r_csb_fall <= ~r_csb_s[1] & r_csb_d;
            r_io_e     <= r_io_s2;
        end
    end

    state_t      r_state, w_next;
    logic        r_nib_odd, r_first, r_clr_pend, r_err;
    logic [3:0]  r_hi_nib;
    logic        w_active, w_byte_done, w_odd_next, w_csb_end, w_frame_err;
    logic        w_push, w_clr_cmd, w_full, w_pop, w_push_ok, w_ovf;
    logic [7:0]  w_byte;

    always_comb begin
        w_active    = (r_state != ST_IDLE);
        w_byte      = {r_hi_nib, r_io_e};
        w_byte_done = w_active & r_rise & r_nib_odd;
        w_odd_next  = r_nib_odd ^ (w_active & r_rise);
        w_csb_end   = w_active & r_csb_rise;
        w_frame_err = w_csb_end & w_odd_next;
        w_push      = (r_state == ST_WRITE) & w_byte_done;
        w_clr_cmd   = (r_state == ST_CMD) & w_byte_done & (w_byte == 8'h07);
        w_next      = r_state;
        case (r_state)
            ST_IDLE: if (r_csb_fall) w_next = ST_CMD;
            ST_CMD: begin
                if (w_byte_done) begin
                    case (w_byte)
                        8'h01:   w_next = ST_WRITE;
`ifdef ML_QSPI_STATUS_EN
                        8'h05:   w_next = ST_STATUS;
`endif
                        default: w_next = ST_IGNORE;
                    endcase
                end
            end
            default: w_next = r_state;
        endcase
        if (w_csb_end) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Nibble pairing, burst start tag, pending error clear and the sticky error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_nib_odd  <= 1'b0;
            r_hi_nib   <= 4'h0;
            r_first    <= 1'b0;
            r_clr_pend <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (!w_active || w_csb_end) begin
                r_nib_odd <= 1'b0;
            end else if (r_rise) begin
                r_nib_odd <= ~r_nib_odd;
                if (!r_nib_odd) r_hi_nib <= r_io_e;
            end
            if (r_state == ST_CMD && w_next == ST_WRITE) r_first <= 1'b1;
            else if (w_push)                             r_first <= 1'b0;
            if (!w_active || w_csb_end) r_clr_pend <= 1'b0;
            else if (w_clr_cmd)         r_clr_pend <= 1'b1;
            if (w_frame_err || w_ovf)                       r_err <= 1'b1;
            else if (w_csb_end && (r_clr_pend || w_clr_cmd)) r_err <= 1'b0;
        end
    end

    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_full    = (r_count == LP_FULL);
    assign w_pop     = cmd_valid & cmd_ready;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf     = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= {r_first, w_byte};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PW'(1);
            if (w_pop)     r_rptr <= r_rptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign cmd_valid   = (r_count != '0);
    assign cmd_data    = cmd_valid ? r_mem[r_rptr][7:0] : 8'h00;
    assign cmd_start   = cmd_valid ? r_mem[r_rptr][8]   : 1'b0;
    assign err         = r_err;
    assign o_dbg_state = r_state;

`ifdef ML_QSPI_STATUS_EN
    logic [3:0] r_do;
    logic       r_sh_hi;
    logic [7:0] w_status;

    assign w_status = {r_err, w_full, ~cmd_valid, status_in};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_do    <= 4'h0;
            r_sh_hi <= 1'b1;
        end else if (w_next != ST_STATUS) begin
            r_do    <= 4'h0;
            r_sh_hi <= 1'b1;
        end else if (r_fall && r_state == ST_STATUS) begin
            r_do    <= r_sh_hi ? w_status[7:4] : w_status[3:0];
            r_sh_hi <= ~r_sh_hi;
        end
    end

    assign spi_io_do = r_do;
    assign spi_io_oe = {4{(r_state == ST_STATUS) & ~r_csb_rise}};
`else
    logic w_unused_status;
    assign w_unused_status = ^{status_in, r_fall};
    assign spi_io_do = 4'h0;
    assign spi_io_oe = 4'h0;
`endif

endmodule
